// File: rtl/multicore_pkg.sv
// -----------------------------------------------------------------------------
// multicore_pkg
// Shared types and helpers for the multicore reset sequencer.
//   global_state_e : HOLD / RELEASE / RUN sequencing of the whole core cluster
//   core_state_e   : ACTIVE / PULSE state of one per-core reset controller
//   MAX_CORES      : upper bound on the number of supervised cores
//   release_point  : stagger-counter value at which a given core is released
// -----------------------------------------------------------------------------
package multicore_pkg;

   localparam int MAX_CORES = 16;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } global_state_e;

   typedef enum logic {
      ACTIVE = 1'b0,
      PULSE  = 1'b1
   } core_state_e;

   // Core k leaves reset when the stagger counter reaches k * stagger.
   function automatic int unsigned release_point(input int unsigned core_idx,
                                                 input int unsigned stagger);
      return core_idx * stagger;
   endfunction

endpackage

// File: rtl/core_reset_ctrl.sv
// -----------------------------------------------------------------------------
// core_reset_ctrl
// Supervision of one core once the cluster is running: a software request or
// a watchdog expiry puts the core into reset for STAGGER_CYCLES cycles.
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   run_i          global sequencer is in RUN; controller is idle otherwise
//   req_i          software reset request (single-cycle pulse)
//   heartbeat_i    watchdog kick (single-cycle pulse)
//   wdt_timeout_i  watchdog expiry count, 0 disables the watchdog
//   wdt_clear_i    clears the sticky fired flag
//   pulse_o        registered per-core reset pulse
//   wdt_fired_o    sticky flag: watchdog expired
// -----------------------------------------------------------------------------
module core_reset_ctrl
   import multicore_pkg::*;
#(
   parameter int STAGGER_CYCLES = 8,
   parameter int WDT_WIDTH      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 run_i,
   input  logic                 req_i,
   input  logic                 heartbeat_i,
   input  logic [WDT_WIDTH-1:0] wdt_timeout_i,
   input  logic                 wdt_clear_i,
   output logic                 pulse_o,
   output logic                 wdt_fired_o
);

   localparam int PCNT_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(STAGGER_CYCLES - 1);

   core_state_e          state_q, state_d;
   logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
   logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
   logic                 pulse_q, pulse_d;
   logic                 fired_q, fired_d;

   logic [WDT_WIDTH-1:0] wdt_inc;
   logic                 expire;

   // Saturating increment: the counter parks at all ones instead of wrapping.
   assign wdt_inc = (wdt_cnt_q == '1) ? wdt_cnt_q : wdt_cnt_q + WDT_WIDTH'(1);

   // The compared count includes the current ACTIVE cycle, so expiry lands
   // exactly wdt_timeout ACTIVE cycles after the last clear. A heartbeat on
   // the same cycle suppresses the expiry.
   assign expire = run_i && (state_q == ACTIVE) && (wdt_timeout_i != '0) &&
                   !heartbeat_i && (wdt_inc == wdt_timeout_i);

   always_comb begin
      // NOTE: every _d gets a default first so no path through this block can
      // infer a latch.
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      wdt_cnt_d = wdt_cnt_q;
      pulse_d   = pulse_q;
      fired_d   = fired_q;

      // Clear is applied first so that a fire on the same cycle overrides it.
      if (wdt_clear_i) begin
         fired_d = 1'b0;
      end

      if (!run_i) begin
         state_d   = ACTIVE;
         pcnt_d    = '0;
         wdt_cnt_d = '0;
         pulse_d   = 1'b0;
      end else begin
         unique case (state_q)
            ACTIVE: begin
               if (req_i || expire) begin
                  state_d   = PULSE;
                  pcnt_d    = '0;
                  pulse_d   = 1'b1;
                  wdt_cnt_d = '0;
               end else if (heartbeat_i) begin
                  wdt_cnt_d = '0;
               end else if (wdt_timeout_i != '0) begin
                  wdt_cnt_d = wdt_inc;
               end
               if (expire) begin
                  fired_d = 1'b1;
               end
            end
            PULSE: begin
               // Requests are ignored here; the pulse length is fixed.
               wdt_cnt_d = '0;
               if (pcnt_q == PCNT_LAST) begin
                  state_d = ACTIVE;
                  pcnt_d  = '0;
                  pulse_d = 1'b0;
               end else begin
                  pcnt_d = pcnt_q + PCNT_W'(1);
               end
            end
            default: begin
               state_d = ACTIVE;
            end
         endcase
      end
   end

   // NOTE: reset is sampled inside the clocked block, so it is synchronous;
   // state updates use non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ACTIVE;
         pcnt_q    <= '0;
         wdt_cnt_q <= '0;
         pulse_q   <= 1'b0;
         fired_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         wdt_cnt_q <= wdt_cnt_d;
         pulse_q   <= pulse_d;
         fired_q   <= fired_d;
      end
   end

   assign pulse_o     = pulse_q;
   assign wdt_fired_o = fired_q;

endmodule

// File: rtl/multicore_reset_sequencer.sv
// -----------------------------------------------------------------------------
// multicore_reset_sequencer
// Reset and supervision controller for an N-core system. Debounces the raw
// pushbutton, releases the cores from reset one after another, then hands
// each core to its own core_reset_ctrl for software / watchdog resets.
//   clock_clk       system clock (only clock)
//   reset_reset     synchronous active-high reset
//   key_n           raw active-low pushbutton, asynchronous
//   core_reset_req  per-core software reset request pulses
//   core_heartbeat  per-core watchdog kick pulses
//   wdt_timeout     watchdog expiry count, 0 disables all watchdogs
//   wdt_clear       clears every wdt_fired flag
//   core_reset      active-high reset per core
//   sys_ready       high once every core has been released
//   wdt_fired       sticky per-core watchdog flags
// -----------------------------------------------------------------------------
module multicore_reset_sequencer
   import multicore_pkg::*;
#(
   parameter int NUM_CORES       = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STAGGER_CYCLES  = 8,
   parameter int WDT_WIDTH       = 16
) (
   input  logic                 clock_clk,
   input  logic                 reset_reset,
   input  logic                 key_n,
   input  logic [NUM_CORES-1:0] core_reset_req,
   input  logic [NUM_CORES-1:0] core_heartbeat,
   input  logic [WDT_WIDTH-1:0] wdt_timeout,
   input  logic                 wdt_clear,
   output logic [NUM_CORES-1:0] core_reset,
   output logic                 sys_ready,
   output logic [NUM_CORES-1:0] wdt_fired
);

   if (NUM_CORES < 1 || NUM_CORES > MAX_CORES) begin : g_bad_num_cores
      $error("NUM_CORES out of range");
   end
   if (DEBOUNCE_CYCLES < 2 || STAGGER_CYCLES < 1) begin : g_bad_timing
      $error("DEBOUNCE_CYCLES or STAGGER_CYCLES out of range");
   end

   localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam int STG_SPAN = (NUM_CORES - 1) * STAGGER_CYCLES;
   localparam int STG_W    = (STG_SPAN > 0) ? $clog2(STG_SPAN + 1) : 1;

   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [STG_W-1:0] LAST_POINT = STG_W'(STG_SPAN);

   // Key path
   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

   // Global sequencer
   global_state_e          gstate_q, gstate_d;
   logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
   logic [STG_W-1:0]       stg_next;
   logic [NUM_CORES-1:0]   hold_mask_q, hold_mask_d;
   logic                   sys_ready_q, sys_ready_d;

   // Per-core controller outputs
   logic [NUM_CORES-1:0]   pulse_vec;
   logic [NUM_CORES-1:0]   fired_vec;
   logic                   run;

   assign run      = (gstate_q == RUN);
   assign stg_next = stg_cnt_q + STG_W'(1);

   // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive synced
   // samples disagree with it; any agreeing sample restarts the count.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   always_comb begin
      gstate_d    = gstate_q;
      stg_cnt_d   = stg_cnt_q;
      hold_mask_d = hold_mask_q;
      sys_ready_d = sys_ready_q;

      unique case (gstate_q)
         HOLD: begin
            hold_mask_d = '1;
            sys_ready_d = 1'b0;
            stg_cnt_d   = '0;
            if (deb_q) begin
               // Core 0 is released on the entry cycle of RELEASE.
               hold_mask_d[0] = 1'b0;
               if (NUM_CORES == 1) begin
                  gstate_d    = RUN;
                  sys_ready_d = 1'b1;
               end else begin
                  gstate_d = RELEASE;
               end
            end
         end
         RELEASE: begin
            stg_cnt_d = stg_next;
            for (int unsigned k = 1; k < NUM_CORES; k++) begin
               if (stg_next == STG_W'(release_point(k, STAGGER_CYCLES))) begin
                  hold_mask_d[k] = 1'b0;
               end
            end
            // sys_ready rises on the same edge the last core is released.
            if (stg_next == LAST_POINT) begin
               gstate_d    = RUN;
               sys_ready_d = 1'b1;
            end
         end
         RUN: begin
            hold_mask_d = '0;
         end
         default: begin
            gstate_d = HOLD;
         end
      endcase

      // A pressed key abandons any release in progress and any pending pulse.
      if (gstate_q != HOLD && !deb_q) begin
         gstate_d    = HOLD;
         hold_mask_d = '1;
         sys_ready_d = 1'b0;
         stg_cnt_d   = '0;
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         // Synchroniser resets to "pressed" so a held-released key still
         // walks through the full synchroniser + debounce latency.
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_q       <= 1'b0;
         deb_cnt_q   <= '0;
         gstate_q    <= HOLD;
         stg_cnt_q   <= '0;
         hold_mask_q <= '1;
         sys_ready_q <= 1'b0;
      end else begin
         sync1_q     <= key_n;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         gstate_q    <= gstate_d;
         stg_cnt_q   <= stg_cnt_d;
         hold_mask_q <= hold_mask_d;
         sys_ready_q <= sys_ready_d;
      end
   end

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      core_reset_ctrl #(
         .STAGGER_CYCLES (STAGGER_CYCLES),
         .WDT_WIDTH      (WDT_WIDTH)
      ) u_ctrl (
         .clk_i         (clock_clk),
         .rst_i         (reset_reset),
         .run_i         (run),
         .req_i         (core_reset_req[i]),
         .heartbeat_i   (core_heartbeat[i]),
         .wdt_timeout_i (wdt_timeout),
         .wdt_clear_i   (wdt_clear),
         .pulse_o       (pulse_vec[i]),
         .wdt_fired_o   (fired_vec[i])
      );
   end

   assign core_reset = hold_mask_q | pulse_vec;
   assign sys_ready  = sys_ready_q;
   assign wdt_fired  = fired_vec;

endmodule

// File: tb/tb_multicore_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicore_reset_sequencer
// Directed bench for multicore_reset_sequencer with default parameters
// (4 cores, 16-cycle debounce, 8-cycle stagger, 16-bit watchdog).
// Inputs are driven at the falling edge and outputs sampled there, so each
// step() covers exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_multicore_reset_sequencer;

   localparam int NUM_CORES = 4;
   localparam int WDT_WIDTH = 16;

   logic                 clock_clk;
   logic                 reset_reset;
   logic                 key_n;
   logic [NUM_CORES-1:0] core_reset_req;
   logic [NUM_CORES-1:0] core_heartbeat;
   logic [WDT_WIDTH-1:0] wdt_timeout;
   logic                 wdt_clear;
   logic [NUM_CORES-1:0] core_reset;
   logic                 sys_ready;
   logic [NUM_CORES-1:0] wdt_fired;

   int n_vec  = 0;
   int n_miss = 0;

   multicore_reset_sequencer #(
      .NUM_CORES       (NUM_CORES),
      .DEBOUNCE_CYCLES (16),
      .STAGGER_CYCLES  (8),
      .WDT_WIDTH       (WDT_WIDTH)
   ) dut (
      .clock_clk      (clock_clk),
      .reset_reset    (reset_reset),
      .key_n          (key_n),
      .core_reset_req (core_reset_req),
      .core_heartbeat (core_heartbeat),
      .wdt_timeout    (wdt_timeout),
      .wdt_clear      (wdt_clear),
      .core_reset     (core_reset),
      .sys_ready      (sys_ready),
      .wdt_fired      (wdt_fired)
   );

   initial clock_clk = 1'b0;
   always #5 clock_clk = ~clock_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_clk);
      @(negedge clock_clk);
   endtask

   // Counts edges from the moment the key / reset is released and records
   // when each core leaves reset and when sys_ready rises.
   task automatic run_sequence(input string tag);
      int fall [NUM_CORES];
      int rdy;
      for (int i = 0; i < NUM_CORES; i++) fall[i] = -1;
      rdy = -1;
      for (int c = 1; c <= 60; c++) begin
         step();
         if (c == 1) check({tag, "_start"}, {27'd0, sys_ready, core_reset}, 32'h0F);
         for (int i = 0; i < NUM_CORES; i++) begin
            if (fall[i] < 0 && !core_reset[i]) fall[i] = c;
         end
         if (rdy < 0 && sys_ready) rdy = c;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         check($sformatf("%s_fall%0d", tag, i), fall[i], 19 + 8 * i);
      end
      check({tag, "_ready"}, rdy, 43);
      check({tag, "_end"}, {27'd0, sys_ready, core_reset}, 32'h10);
   endtask

   // Hand-derived windows for the watchdog phase (edge index c).
   function automatic logic [3:0] exp_rst(input int c);
      logic [3:0] v;
      v    = 4'b0000;
      v[1] = (c >= 50 && c <= 57) || (c >= 108 && c <= 115);
      v[2] = (c >= 220 && c <= 227) || (c >= 278 && c <= 285);
      return v;
   endfunction

   function automatic logic [3:0] exp_fired(input int c);
      logic [3:0] v;
      v    = 4'b0000;
      v[1] = (c >= 50 && c <= 120);
      v[2] = (c >= 220 && c <= 239) || (c >= 278);
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL time_limit: got timeout, expected completion");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      reset_reset    = 1'b1;
      key_n          = 1'b1;
      core_reset_req = '0;
      core_heartbeat = '0;
      wdt_timeout    = '0;
      wdt_clear      = 1'b0;

      // Power-up
      repeat (5) step();
      check("rst_core_reset", core_reset, 4'b1111);
      check("rst_sys_ready", sys_ready, 1'b0);
      check("rst_wdt_fired", wdt_fired, 4'b0000);
      reset_reset = 1'b0;
      run_sequence("pwr");

      // Bounce shorter than the debounce window must be invisible
      for (int c = 0; c < 100; c++) begin
         key_n = ((c / 5) % 2 == 0) ? 1'b0 : 1'b1;
         step();
         check("bounce", {27'd0, sys_ready, core_reset}, 32'h10);
      end
      key_n = 1'b1;
      repeat (3) step();

      // Sustained press: 18 sampled lows, HOLD takes effect on the next edge
      key_n = 1'b0;
      repeat (18) step();
      check("press_edge", {27'd0, sys_ready, core_reset}, 32'h10);
      key_n = 1'b1;
      run_sequence("key");

      // Software reset of core 2, second request mid-pulse is ignored
      core_reset_req = 4'b0100;
      check("swrst_pre", core_reset, 4'b0000);
      for (int p = 1; p <= 10; p++) begin
         step();
         core_reset_req = (p == 4) ? 4'b0100 : 4'b0000;
         check($sformatf("swrst_%0d", p), core_reset, (p <= 8) ? 4'b0100 : 4'b0000);
      end
      check("swrst_flags", wdt_fired, 4'b0000);

      // Watchdog and simultaneity phase
      wdt_timeout = 16'd50;
      for (int c = 1; c <= 281; c++) begin
         core_heartbeat = 4'b0000;
         if (c % 20 == 0) core_heartbeat = (c <= 130) ? 4'b1101 : 4'b1011;
         if (c == 170) core_heartbeat[2] = 1'b1;
         core_reset_req = (c == 220) ? 4'b0100 : 4'b0000;
         wdt_clear      = (c == 121 || c == 240 || c == 278);
         step();
         check($sformatf("wdt_rst_%0d", c), core_reset, exp_rst(c));
         check($sformatf("wdt_flag_%0d", c), wdt_fired, exp_fired(c));
      end
      core_heartbeat = '0;
      core_reset_req = '0;
      wdt_clear      = 1'b0;

      // Reset in the middle of core 2's pulse
      reset_reset = 1'b1;
      step();
      check("midpulse_core_reset", core_reset, 4'b1111);
      check("midpulse_wdt_fired", wdt_fired, 4'b0000);
      check("midpulse_sys_ready", sys_ready, 1'b0);
      wdt_timeout = '0;
      step();
      reset_reset = 1'b0;
      run_sequence("rst_pulse");

      // Reset in the middle of RELEASE
      reset_reset = 1'b1;
      step();
      reset_reset = 1'b0;
      repeat (30) step();
      check("midrel_pre", core_reset, 4'b1100);
      reset_reset = 1'b1;
      step();
      check("midrel_core_reset", core_reset, 4'b1111);
      check("midrel_wdt_fired", wdt_fired, 4'b0000);
      check("midrel_sys_ready", sys_ready, 1'b0);
      reset_reset = 1'b0;
      run_sequence("rst_release");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/multicore_reset_sequencer.md
Name: multicore_reset_sequencer

Overview:
- Parametrised reset and supervision controller for an N-core Nios system. It sits between the board clock/pushbutton and the per-core reset inputs of the multicore system.
- Debounces the raw pushbutton and releases the cores from reset one after another, staggered in time.
- After release, each core can be put back into reset on its own, either by a software request or by a per-core heartbeat watchdog.

Parameters:
- NUM_CORES, 4: number of cores supervised; range 1..16.
- DEBOUNCE_CYCLES, 16: number of consecutive stable synced key samples needed before the debounced level changes; must be >= 2.
- STAGGER_CYCLES, 8: spacing between successive core releases; also the length of a per-core reset pulse; must be >= 1.
- WDT_WIDTH, 16: width of each watchdog counter and of the timeout value.

Ports:
- clock_clk  in  1  system clock; the only clock.
- reset_reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw pushbutton, active low, asynchronous to clock_clk.
- core_reset_req  in  NUM_CORES  software reset request per core; single-cycle pulse.
- core_heartbeat  in  NUM_CORES  per-core watchdog kick; single-cycle pulse.
- wdt_timeout  in  WDT_WIDTH  watchdog expiry count; 0 disables all watchdogs.
- wdt_clear  in  1  clears all wdt_fired flags.
- core_reset  out  NUM_CORES  active-high reset to each core.
- sys_ready  out  1  high once every core has been released.
- wdt_fired  out  NUM_CORES  sticky flag per core: watchdog expired.

Behaviour:
- Reset values:
  - core_reset = all ones.
  - sys_ready = 0.
  - wdt_fired = 0.
  - Debounced key = pressed (0).
  - All counters = 0.
  - FSM = HOLD.
- Key path:
  - key_n goes through a 2-flop synchroniser.
  - The debounced level changes only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any sample that matches the current debounced level resets the debounce counter.
- Global FSM (states HOLD, RELEASE, RUN):
  - HOLD: all core_reset = 1 and sys_ready = 0. Go to RELEASE on the cycle after the debounced key becomes released (1).
  - RELEASE: stagger counter starts at 0 on entry. core_reset[0] drops on the entry cycle. core_reset[k] drops when the counter equals k*STAGGER_CYCLES. A released core stays released. After core NUM_CORES-1 is released, go to RUN.
  - RUN: sys_ready = 1, asserted in the same cycle that core_reset[NUM_CORES-1] falls. Per-core controllers are active.
  - Debounced key pressed while in RELEASE or RUN: go to HOLD. All core_reset = 1 on the next cycle; pending pulses and stagger counter are abandoned. sys_ready drops in the same cycle.
  - reset_reset wins over every other event.
- Per-core controller (states ACTIVE, PULSE), valid only while the global FSM is in RUN:
  - ACTIVE to PULSE: on core_reset_req[i], or on watchdog expiry.
  - PULSE: core_reset[i] = 1 for exactly STAGGER_CYCLES cycles, then return to ACTIVE.
  - A request arriving during PULSE is ignored; the pulse is not extended.
- Watchdog, per core:
  - Counter increments each cycle in ACTIVE while wdt_timeout != 0.
  - Counter clears on core_heartbeat[i], in PULSE, and outside RUN.
  - Expiry: counter == wdt_timeout, non-zero. On expiry, set wdt_fired[i], enter PULSE, clear the counter.
  - Heartbeat in the same cycle as expiry: the heartbeat wins; no fire.
  - core_reset_req and expiry in the same cycle: one pulse, and the flag is set.
  - wdt_clear in the same cycle as a fire: the flag is set (fire wins).
  - Counter saturates at all ones; it never wraps.
  - wdt_timeout changed at runtime: takes effect immediately, compared against the current count.
- Latency:
  - key_n rising to core_reset[0] falling = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - Request to core_reset[i] rising = 1 cycle.

Decomposition:
- Package multicore_pkg holds:
  - typedef enum for the global FSM: HOLD, RELEASE, RUN.
  - typedef enum for the per-core FSM: ACTIVE, PULSE.
  - Constant MAX_CORES = 16.
  - Function for the stagger index computation.
- Sub-module core_reset_ctrl: one per core, generated NUM_CORES times. It holds the per-core FSM, the pulse counter, the watchdog counter and the wdt_fired flag.
- The top level holds the synchroniser, the debouncer, the global FSM and the stagger counter.

Test Plan:
- Power-up: defaults, key_n = 1, reset_reset held 5 cycles then released. Required: core_reset[0] falls 19 cycles after reset release; core_reset[1], [2], [3] fall 8, 16 and 24 cycles after that; sys_ready rises with core_reset[3].
- Bounce: key_n toggles every 5 cycles for 100 cycles during RUN. Required: no change to core_reset or sys_ready. Then key_n held at 0 for 18 cycles. Required: all core_reset = 1 and sys_ready = 0.
- Software reset: core_reset_req = 4'b0100 pulse in RUN. Required: core_reset = 4'b0100 for exactly 8 cycles starting 1 cycle later; other cores unaffected. A second request during the pulse does not extend it.
- Watchdog: wdt_timeout = 50, core 1 never sends a heartbeat, cores 0, 2, 3 heartbeat every 20 cycles. Required: wdt_fired = 4'b0010 after 50 cycles in RUN, an 8-cycle pulse on core 1, then a refire every 58 cycles. wdt_clear clears the flag.
- Simultaneity: core 2 heartbeat on the expiry cycle. Required: no fire. core_reset_req[2] on the expiry cycle. Required: a single pulse and wdt_fired[2] = 1. wdt_clear on the fire cycle. Required: flag stays set.
- Mid-operation reset: reset_reset asserted in the middle of RELEASE and in the middle of a PULSE. Required: next cycle core_reset = 4'b1111, wdt_fired = 0, sys_ready = 0, and the full sequence restarts.
